fft_reorder: RTL and testbench
==============================

Name: fft_reorder

Overview:
- Output reorder buffer at the consumer end of the radix-2^2 SDF FFT pipeline.
- The SDF chain emits each N-point frame in bit-reversed index order as a contiguous do_en burst; this block accepts that stream and re-emits every frame in natural order.
- Ping-pong buffering across two frame banks sustains back-to-back frames.
- Adds an optional downstream hold and reports overflow and frame errors.

Parameters:
- N, 64, FFT points per frame; power of 2, at least 4.
- WIDTH, 16, data bit length per real/imag component.

Ports:
- clock  input  1  master clock.
- reset  input  1  synchronous reset, active-low.
- di_en  input  1  input data enable; high for contiguous N-sample frames (bit-reversed order).
- di_re  input  WIDTH  input data, real.
- di_im  input  WIDTH  input data, imag.
- do_hold  input  1  downstream hold; pauses output reads.
- do_en  output  1  output data enable.
- do_re  output  WIDTH  output data, real, natural order.
- do_im  output  WIDTH  output data, imag, natural order.
- do_last  output  1  high with the final (index N-1) output sample of a frame.
- ovf  output  1  sticky overflow flag.
- frm_err  output  1  one-cycle pulse when a partial input frame is discarded.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a clock edge):
  - do_en, do_last, ovf, frm_err, do_re and do_im are 0.
  - Both banks are EMPTY; write count = 0; wr_bank = 0; rd_bank = 0; reader is IDLE.
  - RAM contents are not reset.
  - Reset mid-frame or mid-read discards everything in flight.
- Storage: two banks of N x 2*WIDTH each. Each bank has state EMPTY -> FILLING -> FULL -> READING -> EMPTY.
- Write side:
  - Each di_en=1 cycle writes sample k (write count) into bank wr_bank at address bitrev_log2N(k), then increments k.
  - When k==N-1 is written: the bank becomes FULL, k wraps to 0, and wr_bank toggles.
  - The next di_en cycle may start a new frame immediately, with no gap required.
- Partial frame: di_en=0 while 0<k<N:
  - The frame is discarded and the bank returns to EMPTY; k = 0; wr_bank is unchanged.
  - frm_err pulses high on the following cycle.
- Overflow: a frame starts (di_en=1 with k==0) while bank wr_bank is FULL or READING.
  - The whole incoming frame is dropped: no writes occur, and k still counts so that frame boundaries are kept.
  - ovf sets on the next cycle and stays set until reset.
  - The existing bank contents and wr_bank are unchanged.
- Reader FSM, IDLE/READ:
  - IDLE -> READ when bank rd_bank is FULL. That bank becomes READING and read address r = 0.
  - In READ, each cycle with do_hold=0 issues RAM read r and increments r. A cycle with do_hold=1 issues nothing and holds r.
  - After r==N-1 is issued: the bank becomes EMPTY and rd_bank toggles.
  - If the other bank is already FULL, the reader goes directly to READ with r=0 on the next cycle (no gap). Otherwise it returns to IDLE.
- Output timing:
  - RAM read latency is 1 cycle, registered. A read issued in cycle t gives do_en=1 with data in cycle t+1.
  - do_last=1 when the issued address was N-1.
  - When do_en=0, do_re and do_im hold their last value.
- Latency: the first output sample appears N+1 cycles after the first input sample of a frame (input at cycle 0, output at cycle N+1) when do_hold=0.
- Simultaneous events:
  - A write to one bank and a read from the other bank in the same cycle is legal.
  - A bank's state transition from the writer (to FULL) and from the reader (to EMPTY) never occurs on the same bank in the same cycle, because the overflow rule prevents it.
- Throughput: with do_hold=0, continuous input gives continuous output. Never overflows.

Test Plan:
1. N=16, one frame, di_re=k, di_im=-k for k=0..15, do_hold=0 -> do_en high cycles 17..32; do_re = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; do_im is the negation of do_re; do_last only at cycle 32.
2. N=16, three back-to-back frames (48 di_en cycles) -> 48 contiguous do_en cycles from cycle 17; do_last at cycles 32, 48 and 64; ovf=0.
3. N=16, three back-to-back frames with do_hold=1 during cycles 16..40 -> frame 2 is dropped; ovf=1 from cycle 33 onward; frames 0 and 1 are output intact in natural order.
4. N=16, di_en high for 5 cycles then low, then one full frame -> frm_err pulse one cycle after di_en falls; only the full frame appears at the output, correctly ordered.
5. reset=0 for one cycle mid-output of frame 0 -> do_en=0 from the next cycle; ovf=0; a subsequent frame is output with latency N+1.
6. N=64 default, di_re=k -> output index 1 carries 32, index 2 carries 16, index 63 carries 63.

Source files
------------

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong reorder buffer turning bit-reversed SDF FFT frames
// into natural-order frames, with downstream hold, overflow and frame-error flags.
module fft_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  input  logic             do_hold,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_last,
  output logic             ovf,
  output logic             frm_err
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_t;
  typedef enum logic {RD_IDLE, RD_READ} rd_t;

  logic [2*WIDTH-1:0] mem [2*N];

  bank_t         bank_st  [2];
  bank_t         bank_nxt [2];
  rd_t           rd_st, rd_st_nxt;
  logic [AW-1:0] wr_cnt, wr_cnt_nxt;
  logic [AW-1:0] rd_addr, rd_addr_nxt;
  logic          wr_bank, wr_bank_nxt;
  logic          rd_bank, rd_bank_nxt;
  logic          drop, drop_nxt;
  logic          wr_start, wr_blocked, wr_do;
  logic          ovf_evt, ferr_evt;
  logic          rd_go, rd_issue;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    for (int unsigned i = 0; i < AW; i++) b[i] = a[AW-1-i];
    return b;
  endfunction

  // Next-state for writer, reader and both bank states.
  // The reader also issues from IDLE in the cycle it finds a FULL bank, so
  // the first sample leaves N+1 cycles after the first input and the frame
  // boundary between back-to-back frames has no bubble.
  always_comb begin
    bank_nxt    = bank_st;
    rd_st_nxt   = rd_st;
    wr_cnt_nxt  = wr_cnt;
    rd_addr_nxt = rd_addr;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    drop_nxt    = drop;

    wr_start   = di_en && (wr_cnt == '0);
    wr_blocked = (bank_st[wr_bank] == B_FULL) || (bank_st[wr_bank] == B_READING);
    ovf_evt    = wr_start && wr_blocked;
    wr_do      = di_en && (wr_start ? !wr_blocked : !drop);
    ferr_evt   = !di_en && (wr_cnt != '0);

    if (wr_start) drop_nxt = wr_blocked;

    if (di_en) begin
      wr_cnt_nxt = wr_cnt + AW'(1);
      if (wr_do && wr_start) bank_nxt[wr_bank] = B_FILLING;
      if (wr_do && (wr_cnt == LAST)) begin
        bank_nxt[wr_bank] = B_FULL;
        wr_bank_nxt       = ~wr_bank;
      end
    end else if (ferr_evt) begin
      wr_cnt_nxt = '0;
      if (!drop) bank_nxt[wr_bank] = B_EMPTY;
    end

    rd_go = (rd_st == RD_READ) || (bank_st[rd_bank] == B_FULL);
    if ((rd_st == RD_IDLE) && (bank_st[rd_bank] == B_FULL)) begin
      bank_nxt[rd_bank] = B_READING;
      rd_st_nxt         = RD_READ;
    end
    rd_issue = rd_go && !do_hold;
    if (rd_issue) begin
      rd_addr_nxt = rd_addr + AW'(1);
      if (rd_addr == LAST) begin
        bank_nxt[rd_bank] = B_EMPTY;
        rd_bank_nxt       = ~rd_bank;
        rd_addr_nxt       = '0;
        if (bank_st[~rd_bank] == B_FULL) begin
          bank_nxt[~rd_bank] = B_READING;
          rd_st_nxt          = RD_READ;
        end else begin
          rd_st_nxt = RD_IDLE;
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      rd_st      <= RD_IDLE;
      wr_cnt     <= '0;
      rd_addr    <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      drop       <= 1'b0;
    end else begin
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
      rd_st      <= rd_st_nxt;
      wr_cnt     <= wr_cnt_nxt;
      rd_addr    <= rd_addr_nxt;
      wr_bank    <= wr_bank_nxt;
      rd_bank    <= rd_bank_nxt;
      drop       <= drop_nxt;
    end
  end

  // Sample RAM: write at the bit-reversed slot of the current bank.
  always_ff @(posedge clock) begin
    if (wr_do) mem[{wr_bank, bitrev(wr_cnt)}] <= {di_re, di_im};
  end

  // Registered read port and status flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      do_en   <= 1'b0;
      do_last <= 1'b0;
      do_re   <= '0;
      do_im   <= '0;
      ovf     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      do_en   <= rd_issue;
      do_last <= rd_issue && (rd_addr == LAST);
      if (rd_issue) {do_re, do_im} <= mem[{rd_bank, rd_addr}];
      ovf     <= ovf | ovf_evt;
      frm_err <= ferr_evt;
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: directed tests for fft_reorder (N=16 and default N=64)
// against a sample-queue reference model plus hand-computed expectations.
module tb_fft_reorder;
  localparam int N16 = 16;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic         di_en = 1'b0, do_hold = 1'b0;
  logic [W-1:0] di_re = '0, di_im = '0;
  logic         do_en, do_last, ovf, frm_err;
  logic [W-1:0] do_re, do_im;

  logic         di_en64 = 1'b0;
  logic [W-1:0] di_re64 = '0;
  logic         do_en64, do_last64, ovf64, frm_err64;
  logic [W-1:0] do_re64, do_im64;

  fft_reorder #(.N(16), .WIDTH(16)) dut (
    .clock(clk), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_hold(do_hold), .do_en(do_en), .do_re(do_re), .do_im(do_im),
    .do_last(do_last), .ovf(ovf), .frm_err(frm_err));

  fft_reorder #(.WIDTH(16)) dut64 (
    .clock(clk), .reset(reset), .di_en(di_en64), .di_re(di_re64), .di_im(16'h0000),
    .do_hold(1'b0), .do_en(do_en64), .do_re(do_re64), .do_im(do_im64),
    .do_last(do_last64), .ovf(ovf64), .frm_err(frm_err64));

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0;
  int tcyc = 0, t0 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, tcyc - t0, act, exp);
    end
  endtask

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (v[i]) r |= (1 << (bits - 1 - i));
    return r;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Reference model: completed frames become a natural-order sample queue;
  // a frame start is dropped when two frames are still held.
  logic [31:0]  mq[$];
  logic [31:0]  cur [N16];
  int           mk = 0;
  bit           mdrop = 0, mdl_ok = 0;
  logic         exp_en, exp_last, exp_ovf, exp_ferr;
  logic [W-1:0] exp_re, exp_im;

  always @(posedge clk) begin : mdl
    int occ;
    logic [31:0] s;
    if (!reset) begin
      mq.delete();
      mk = 0; mdrop = 0; mdl_ok = 1;
      exp_en = 0; exp_last = 0; exp_ovf = 0; exp_ferr = 0;
      exp_re = '0; exp_im = '0;
    end else if (mdl_ok) begin
      occ = (mq.size() + N16 - 1) / N16;
      exp_en = 0; exp_last = 0; exp_ferr = 0;
      if (mq.size() > 0 && !do_hold) begin
        s = mq.pop_front();
        exp_en = 1;
        exp_re = s[31:16];
        exp_im = s[15:0];
        exp_last = (mq.size() % N16 == 0);
      end
      if (di_en) begin
        if (mk == 0) begin
          mdrop = (occ == 2);
          if (mdrop) exp_ovf = 1;
        end
        if (!mdrop) cur[brev(mk, 4)] = {di_re, di_im};
        if (mk == N16 - 1) begin
          if (!mdrop) for (int j = 0; j < N16; j++) mq.push_back(cur[j]);
          mk = 0;
        end else begin
          mk++;
        end
      end else if (mk != 0) begin
        exp_ferr = 1;
        mk = 0;
      end
    end
  end

  always @(posedge clk) tcyc <= tcyc + 1;

  // Every-cycle comparison of the N=16 DUT against the model.
  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("do_en", do_en, exp_en);
      chk("do_re", do_re, exp_re);
      chk("do_im", do_im, exp_im);
      chk("do_last", do_last, exp_last);
      chk("ovf", ovf, exp_ovf);
      chk("frm_err", frm_err, exp_ferr);
    end
  end

  // Event logs for the hand-computed checks.
  int o_re[$], o_im[$], o_cyc[$], l_cyc[$], e_cyc[$];
  int ovf_cyc = -1;
  int o64_re[$];
  int o64_first = -1;

  always @(negedge clk) begin
    if (do_en) begin
      o_re.push_back(int'(do_re));
      o_im.push_back(int'(do_im));
      o_cyc.push_back(tcyc - t0);
    end
    if (do_last) l_cyc.push_back(tcyc - t0);
    if (ovf && ovf_cyc < 0) ovf_cyc = tcyc - t0;
    if (frm_err) e_cyc.push_back(tcyc - t0);
    if (do_en64) begin
      if (o64_first < 0) o64_first = tcyc - t0;
      o64_re.push_back(int'(do_re64));
    end
  end

  task automatic clear_logs();
    o_re.delete(); o_im.delete(); o_cyc.delete(); l_cyc.delete(); e_cyc.delete();
    o64_re.delete(); ovf_cyc = -1; o64_first = -1;
  endtask

  task automatic step(input bit en, input int re, input int im, input bit hold);
    @(negedge clk);
    di_en = en; di_re = W'(re); di_im = W'(im); do_hold = hold;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; di_en = 1'b0; do_hold = 1'b0; di_en64 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  int exp1 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  initial begin
    // 1: single frame
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step(1, c, -c, 0);
      if (c == 0) t0 = tcyc;
    end
    idle(30);
    chk("t1_count", o_re.size(), 16);
    for (int j = 0; j < 16; j++) begin
      chk("t1_re", qget(o_re, j), exp1[j]);
      chk("t1_im", qget(o_im, j), (-exp1[j]) & 16'hFFFF);
      chk("t1_cyc", qget(o_cyc, j), 17 + j);
    end
    chk("t1_last_n", l_cyc.size(), 1);
    chk("t1_last", qget(l_cyc, 0), 32);

    // 2: three back-to-back frames
    do_reset();
    for (int c = 0; c < 48; c++) begin
      step(1, c, -c, 0);
      if (c == 0) t0 = tcyc;
    end
    idle(40);
    chk("t2_count", o_re.size(), 48);
    for (int i = 0; i < 48; i++) begin
      chk("t2_re", qget(o_re, i), (i / 16) * 16 + exp1[i % 16]);
      chk("t2_cyc", qget(o_cyc, i), 17 + i);
    end
    chk("t2_last_n", l_cyc.size(), 3);
    chk("t2_last0", qget(l_cyc, 0), 32);
    chk("t2_last1", qget(l_cyc, 1), 48);
    chk("t2_last2", qget(l_cyc, 2), 64);
    chk("t2_ovf", ovf_cyc, -1);

    // 3: hold forces third frame to overflow
    do_reset();
    for (int c = 0; c < 48; c++) begin
      step(1, c, -c, (c >= 16 && c <= 40));
      if (c == 0) t0 = tcyc;
    end
    idle(60);
    chk("t3_ovf_cyc", ovf_cyc, 33);
    chk("t3_count", o_re.size(), 32);
    for (int i = 0; i < 32; i++) chk("t3_re", qget(o_re, i), (i / 16) * 16 + exp1[i % 16]);
    chk("t3_first", qget(o_cyc, 0), 42);
    chk("t3_last0", qget(l_cyc, 0), 57);
    chk("t3_last1", qget(l_cyc, 1), 73);

    // 4: partial frame then a full one
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(1, 100 + c, 0, 0);
      if (c == 0) t0 = tcyc;
    end
    step(0, 0, 0, 0);
    for (int c = 0; c < 16; c++) step(1, c, -c, 0);
    idle(40);
    chk("t4_ferr_n", e_cyc.size(), 1);
    chk("t4_ferr", qget(e_cyc, 0), 6);
    chk("t4_count", o_re.size(), 16);
    for (int j = 0; j < 16; j++) chk("t4_re", qget(o_re, j), exp1[j]);
    chk("t4_first", qget(o_cyc, 0), 23);
    chk("t4_ovf", ovf_cyc, -1);

    // 5: reset during output, then a fresh frame
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step(1, c, -c, 0);
      if (c == 0) t0 = tcyc;
    end
    idle(4);
    @(negedge clk);
    reset = 1'b0; di_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(10);
    chk("t5_count", o_re.size(), 4);
    chk("t5_lastout", qget(o_cyc, 3), 20);
    chk("t5_nolast", l_cyc.size(), 0);
    chk("t5_ovf", ovf_cyc, -1);
    clear_logs();
    for (int c = 0; c < 16; c++) begin
      step(1, 200 + c, 0, 0);
      if (c == 0) t0 = tcyc;
    end
    idle(30);
    chk("t5b_count", o_re.size(), 16);
    chk("t5b_first", qget(o_cyc, 0), 17);
    for (int j = 0; j < 16; j++) chk("t5b_re", qget(o_re, j), 200 + exp1[j]);

    // 6: default N=64
    do_reset();
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      di_en64 = 1'b1; di_re64 = W'(c);
      if (c == 0) t0 = tcyc;
    end
    @(negedge clk);
    di_en64 = 1'b0;
    idle(80);
    chk("t6_count", o64_re.size(), 64);
    chk("t6_first", o64_first, 65);
    chk("t6_idx1", qget(o64_re, 1), 32);
    chk("t6_idx2", qget(o64_re, 2), 16);
    chk("t6_idx63", qget(o64_re, 63), 63);
    for (int j = 0; j < 64; j++) chk("t6_re", qget(o64_re, j), brev(j, 6));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
